// File: rtl/dm_port_arbiter.sv
// Two-master round-robin arbiter and sequencer for the byte-enabled data memory.
// Grants one access at a time, drives lane-shifted memory signals and returns aligned, registered responses.
module dm_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [1:0]  i_p0_size,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [1:0]  i_p1_size,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p0_done,
  output logic        o_p0_err,
  output logic        o_p1_done,
  output logic        o_p1_err,
  output logic [31:0] o_rdata,
  output logic        o_m_en,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [3:0]  o_m_be,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   f_aligned = (a == 2'b00);
      2'b10:   f_aligned = (a[0] == 1'b0);
      2'b11:   f_aligned = 1'b1;
      default: f_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   f_be = 4'b1111;
      2'b10:   f_be = a[1] ? 4'b1100 : 4'b0011;
      2'b11:   f_be = 4'b0001 << a;
      default: f_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_lane_wdata(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] wd);
    case (size)
      2'b01:   f_lane_wdata = wd;
      2'b10:   f_lane_wdata = a[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
      2'b11:   f_lane_wdata = {24'h000000, wd[7:0]} << {a, 3'b000};
      default: f_lane_wdata = 32'h0000_0000;
    endcase
  endfunction

  // Load data is shifted down from its lanes and zero-extended
  function automatic logic [31:0] f_load(input logic [1:0] size, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (size)
      2'b01:   f_load = rd;
      2'b10:   f_load = {16'h0000, sh[15:0]};
      2'b11:   f_load = {24'h000000, sh[7:0]};
      default: f_load = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic        r_port;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_p0_done, r_p1_done, r_p0_err, r_p1_err;
  logic [31:0] r_rdata;

  logic        w_any_req;
  logic        w_grant1;
  logic        w_sel_we;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_acc;

  assign w_any_req = i_p0_req | i_p1_req;

  // Round-robin winner: on a tie the port that did not win last time goes
  always_comb begin
    w_grant1 = 1'b0;
    if (i_p0_req && i_p1_req) begin
      w_grant1 = ~r_last;
    end else if (i_p1_req) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant1 = 1'b0;
    end
  end

  assign w_sel_we    = w_grant1 ? i_p1_we    : i_p0_we;
  assign w_sel_size  = w_grant1 ? i_p1_size  : i_p0_size;
  assign w_sel_addr  = w_grant1 ? i_p1_addr  : i_p0_addr;
  assign w_sel_wdata = w_grant1 ? i_p1_wdata : i_p0_wdata;

  // Sequencer FSM plus registered completion outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 8'd0;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_addr    <= 32'h0000_0000;
      r_wdata   <= 32'h0000_0000;
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_p0_err  <= 1'b0;
      r_p1_err  <= 1'b0;
      r_rdata   <= 32'h0000_0000;
    end else begin
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_p0_err  <= 1'b0;
      r_p1_err  <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_port  <= w_grant1;
            r_last  <= w_grant1;
            r_we    <= w_sel_we;
            r_size  <= w_sel_size;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= 8'd0;
            if (f_aligned(w_sel_size, w_sel_addr[1:0])) begin
              r_state <= ACCESS;
            end else begin
              r_state   <= RESP;
              r_p0_done <= ~w_grant1;
              r_p1_done <= w_grant1;
              r_p0_err  <= ~w_grant1;
              r_p1_err  <= w_grant1;
            end
          end
        end
        ACCESS: begin
          if (i_m_ready) begin
            r_state   <= RESP;
            r_p0_done <= ~r_port;
            r_p1_done <= r_port;
            r_rdata   <= r_we ? 32'h0000_0000 : f_load(r_size, r_addr[1:0], i_m_rdata);
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state   <= RESP;
            r_p0_done <= ~r_port;
            r_p1_done <= r_port;
            r_p0_err  <= ~r_port;
            r_p1_err  <= r_port;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_acc     = (r_state == ACCESS);
  assign o_m_en    = w_acc;
  assign o_m_we    = w_acc & r_we;
  assign o_m_addr  = w_acc ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
  assign o_m_be    = w_acc ? f_be(r_size, r_addr[1:0]) : 4'b0000;
  assign o_m_wdata = (w_acc && r_we) ? f_lane_wdata(r_size, r_addr[1:0], r_wdata) : 32'h0000_0000;

  assign o_p0_done = r_p0_done;
  assign o_p1_done = r_p1_done;
  assign o_p0_err  = r_p0_err;
  assign o_p1_err  = r_p1_err;
  assign o_rdata   = r_rdata;

endmodule
